// File: rtl/tl_pkg.sv
// TileLink-UL channel payload types shared by the peripheral fabric.
package tl_pkg;

  localparam int unsigned TL_SRC_W  = 8;
  localparam int unsigned TL_ADDR_W = 32;
  localparam int unsigned TL_DATA_W = 32;
  localparam int unsigned TL_SIZE_W = 2;
  localparam int unsigned TL_MASK_W = TL_DATA_W / 8;

  typedef enum logic [2:0] {
    A_PUT_FULL    = 3'h0,
    A_PUT_PARTIAL = 3'h1,
    A_GET         = 3'h4
  } a_opcode_e;

  typedef enum logic [2:0] {
    D_ACCESS_ACK      = 3'h0,
    D_ACCESS_ACK_DATA = 3'h1
  } d_opcode_e;

  typedef struct packed {
    a_opcode_e              opcode;
    logic [2:0]             param;
    logic [TL_SIZE_W-1:0]   size;
    logic [TL_SRC_W-1:0]    source;
    logic [TL_ADDR_W-1:0]   address;
    logic [TL_MASK_W-1:0]   mask;
    logic [TL_DATA_W-1:0]   data;
    logic                   corrupt;
  } A_chan_bits_t;

  typedef struct packed {
    d_opcode_e              opcode;
    logic [1:0]             param;
    logic [TL_SIZE_W-1:0]   size;
    logic [TL_SRC_W-1:0]    source;
    logic                   sink;
    logic                   denied;
    logic [TL_DATA_W-1:0]   data;
    logic                   corrupt;
  } D_chan_bits_t;

endpackage

// File: rtl/tl_apb_arb.sv
// Round-robin arbiter sharing one TL-to-APB bridge port among NUM_REQ
// requesters, one outstanding transaction at a time, response routed by grant.
// Optional watchdog in WAIT: define TL_APB_ARB_TIMEOUT_EN.
module tl_apb_arb
  import tl_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_A_valid_i,
  output logic [NUM_REQ-1:0]         req_A_ready_o,
  input  A_chan_bits_t               req_A_bits_i [NUM_REQ],
  output logic [NUM_REQ-1:0]         req_D_valid_o,
  input  logic [NUM_REQ-1:0]         req_D_ready_i,
  output D_chan_bits_t               req_D_bits_o,
  output logic                       TL_A_valid_o,
  input  logic                       TL_A_ready_i,
  output A_chan_bits_t               TL_A_bits_o,
  input  logic                       TL_D_valid_i,
  output logic                       TL_D_ready_o,
  input  D_chan_bits_t               TL_D_bits_i,
  output logic                       busy_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_o
);

  localparam int unsigned GW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES == 0) begin : g_bad_param
    $error("tl_apb_arb: NUM_REQ must be 2..16 and TIMEOUT_CYCLES nonzero");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [GW-1:0] grant_q, grant_d;
  A_chan_bits_t  a_q, a_d;
  D_chan_bits_t  d_q, d_d;
  logic          any_req_c;
  logic [GW-1:0] winner_c;
  logic [GW-1:0] grant_next_c;

`ifdef TL_APB_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          drain_q, drain_d;
  D_chan_bits_t  err_rsp_c;
`endif

  function automatic logic [GW-1:0] wrap_idx(input logic [GW-1:0] base,
                                             input int unsigned off);
    return GW'((32'(base) + off) % NUM_REQ);
  endfunction

  // First valid requester at or above rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    any_req_c = 1'b0;
    winner_c  = rr_ptr_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!any_req_c && req_A_valid_i[wrap_idx(rr_ptr_q, i)]) begin
        any_req_c = 1'b1;
        winner_c  = wrap_idx(rr_ptr_q, i);
      end
    end
  end

  // Pointer value after the current owner finishes
  always_comb begin
    grant_next_c = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);
  end

`ifdef TL_APB_ARB_TIMEOUT_EN
  // Synthesised error response for a bridge that never answers
  always_comb begin
    err_rsp_c        = '0;
    err_rsp_c.opcode = (a_q.opcode == A_GET) ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;
    err_rsp_c.size   = a_q.size;
    err_rsp_c.source = a_q.source;
    err_rsp_c.denied = 1'b1;
  end
`endif

  // Next-state and datapath capture
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    a_d      = a_q;
    d_d      = d_q;
`ifdef TL_APB_ARB_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
    drain_d  = drain_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (any_req_c) begin
          grant_d = winner_c;
          a_d     = req_A_bits_i[winner_c];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (TL_A_ready_i) begin
          state_d = S_WAIT;
`ifdef TL_APB_ARB_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end
      end
      S_WAIT: begin
        if (TL_D_valid_i) begin
          d_d     = TL_D_bits_i;
          state_d = S_RESP;
        end
`ifdef TL_APB_ARB_TIMEOUT_EN
        else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          d_d     = err_rsp_c;
          drain_d = 1'b1;
          state_d = S_RESP;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
`endif
      end
      S_RESP: begin
        if (req_D_ready_i[grant_q]) begin
          rr_ptr_d = grant_next_c;
`ifdef TL_APB_ARB_TIMEOUT_EN
          state_d  = drain_q ? S_DRAIN : S_IDLE;
`else
          state_d  = S_IDLE;
`endif
        end
      end
      S_DRAIN: begin
`ifdef TL_APB_ARB_TIMEOUT_EN
        // Swallow the late beat of the timed-out transaction
        if (TL_D_valid_i) begin
          drain_d = 1'b0;
          state_d = S_IDLE;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      a_q      <= '0;
      d_q      <= '0;
`ifdef TL_APB_ARB_TIMEOUT_EN
      to_cnt_q <= '0;
      drain_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      a_q      <= a_d;
      d_q      <= d_d;
`ifdef TL_APB_ARB_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
      drain_q  <= drain_d;
`endif
    end
  end

  // Per-requester handshakes; A ready is the only bridge-to-requester pass-through
  always_comb begin
    req_A_ready_o = '0;
    req_D_valid_o = '0;
    if (state_q == S_ISSUE) req_A_ready_o[grant_q] = TL_A_ready_i;
    if (state_q == S_RESP)  req_D_valid_o[grant_q] = 1'b1;
  end

  assign TL_A_valid_o = (state_q == S_ISSUE);
  assign TL_A_bits_o  = a_q;
  assign TL_D_ready_o = (state_q == S_WAIT) || (state_q == S_DRAIN);
  assign req_D_bits_o = d_q;
  assign busy_o       = (state_q != S_IDLE);
  assign grant_o      = grant_q;

endmodule

// File: doc/tl_apb_arb.md
# tl_apb_arb

Round-robin arbiter that shares the single TileLink-to-APB bridge port among `NUM_REQ` TileLink requesters. It allows exactly one outstanding transaction at a time and routes the single D-channel response back to the requester that issued it. It sits between the peripheral-side crossbar outputs and the TL A/D ports of the APB bridge. It registers both channels, so no combinational path exists from a requester through to the bridge.

## Interface
- `NUM_REQ`, default 4: number of requester ports; range 2..16.
- `TIMEOUT_CYCLES`, default 1024: watchdog limit in WAIT state; only used when the timeout feature is compiled in (see Configuration).

Clock and reset (already decided):
- `clk_i`, in, 1 bit: single clock.
- `rst_i`, in, 1 bit: reset, asynchronous, active-low.

Requester side:
- `req_A_valid_i`, in, [NUM_REQ]: per-requester A valid.
- `req_A_ready_o`, out, [NUM_REQ]: per-requester A ready.
- `req_A_bits_i`, in, `tl_pkg::A_chan_bits_t` [NUM_REQ]: per-requester A payload.
- `req_D_valid_o`, out, [NUM_REQ]: per-requester D valid.
- `req_D_ready_i`, in, [NUM_REQ]: per-requester D ready.
- `req_D_bits_o`, out, `tl_pkg::D_chan_bits_t`: shared D payload; it is meaningful only for the requester whose `req_D_valid_o` is set.

Bridge side:
- `TL_A_valid_o`, out, 1 bit: A valid to the bridge.
- `TL_A_ready_i`, in, 1 bit: A ready from the bridge.
- `TL_A_bits_o`, out, `tl_pkg::A_chan_bits_t`: A payload to the bridge.
- `TL_D_valid_i`, in, 1 bit: D valid from the bridge.
- `TL_D_ready_o`, out, 1 bit: D ready to the bridge.
- `TL_D_bits_i`, in, `tl_pkg::D_chan_bits_t`: D payload from the bridge.

Status:
- `busy_o`, out, 1 bit: high whenever the state is not IDLE.
- `grant_o`, out, $clog2(NUM_REQ) bits: index of the current owner.

## Operation
States are IDLE, ISSUE, WAIT, RESP, DRAIN.

- **IDLE**
  - The winner is the first set bit of `req_A_valid_i` found by searching upward from `rr_ptr`, wrapping modulo NUM_REQ.
  - The winner's index goes into `grant_q`, its A bits go into `a_q`, and the state moves to ISSUE.
  - No `req_A_ready_o` is asserted in IDLE. Requesters must hold valid and bits stable until accepted (TL rule).
- **ISSUE**
  - `TL_A_valid_o` = 1 and `TL_A_bits_o` = `a_q`.
  - `req_A_ready_o[grant_q]` = `TL_A_ready_i`; all other ready outputs are 0.
  - When `TL_A_valid_o && TL_A_ready_i`, the state moves to WAIT.
- **WAIT**
  - `TL_D_ready_o` = 1.
  - When `TL_D_valid_i` is seen, `TL_D_bits_i` is captured into `d_q` and the state moves to RESP.
- **RESP**
  - `req_D_valid_o[grant_q]` = 1 and `req_D_bits_o` = `d_q`.
  - When `req_D_ready_i[grant_q]` is seen, `rr_ptr` is set to `grant_q+1` (mod NUM_REQ).
  - The next state is DRAIN if `drain_q` is set, otherwise IDLE.
- **DRAIN**
  - `TL_D_ready_o` = 1.
  - The first `TL_D_valid_i` beat is discarded, `drain_q` is cleared, and the state moves to IDLE.
- A D beat from the bridge outside WAIT/DRAIN is a protocol error. `TL_D_ready_o` stays 0, so the beat is back-pressured rather than lost.
- Requests arriving while the arbiter is not in IDLE wait. They are never dropped.
- Requester `source` values pass through unmodified. Routing uses `grant_q` only.

## Timing
- **Reset values:** state = IDLE, `rr_ptr` = 0, `grant_q` = 0, `drain_q` = 0. All valid and ready outputs are 0, `busy_o` = 0, `grant_o` = 0, and the bits outputs are 0.
- **Reset mid-operation:** an assertion returns the block to IDLE immediately. No D response is generated for a lost transaction.
- **A latency:** `TL_A_valid_o` rises one cycle after the winning `req_A_valid_i` is seen in IDLE.
- **D latency:** `req_D_valid_o` rises one cycle after the `TL_D_valid_i` beat.
- **Minimum occupancy:** 4 cycles per transaction (IDLE, ISSUE, WAIT with same-cycle D, RESP with same-cycle ready). There is no back-to-back bypass.
- **Simultaneous requests:** only one wins per arbitration. With all requesters valid continuously, grants rotate 0, 1, 2, 3, 0, ... for NUM_REQ = 4.
- **Wrap-around:** `rr_ptr` = NUM_REQ-1 followed by a grant to NUM_REQ-1 sets `rr_ptr` to 0.

## Configuration
The timeout feature is controlled by the macro `TL_APB_ARB_TIMEOUT_EN`.

Defined:
- A counter resets on entry to WAIT and increments each WAIT cycle.
- When the counter reaches `TIMEOUT_CYCLES-1` with no `TL_D_valid_i`, `d_q` is loaded with an error response:
  - opcode = AccessAckData if `a_q` is a Get, else AccessAck;
  - `size`/`source` from `a_q`; `data` = 0;
  - `denied` = 1, `corrupt` = 0.
- At the same time `drain_q` is set and the state moves to RESP.
- If `TL_D_valid_i` arrives in the same cycle as the limit, the real beat wins and no timeout occurs.

Not defined:
- WAIT waits indefinitely. The counter, `drain_q` and DRAIN logic are absent, and DRAIN is unreachable.

## Test plan
- **Single Get:** requester 2 issues a Get at address 0x1000 with source 5, and the bridge answers 3 cycles later with data 0xDEADBEEF. Requester 2 receives that D with source 5. The beat is not visible on other ports (`req_D_valid_o[n]` = 0 for n ≠ 2). `busy_o` returns to 0.
- **All four requesters valid in the same cycle:** grants are 0, 1, 2, 3, then 0 again. Each requester gets exactly one response per grant.
- **Back-pressure:** `TL_A_ready_i` is held low for 5 cycles and `req_D_ready_i[1]` is held low for 7 cycles. `TL_A_valid_o` and `TL_A_bits_o` stay stable throughout, `req_D_bits_o` stays stable, and no transaction is duplicated.
- **Timeout (macro defined, TIMEOUT_CYCLES = 8):** the bridge stays silent. After 8 WAIT cycles requester 0 receives `denied` = 1. A late bridge beat is then consumed in DRAIN and is not forwarded.
- **Reset mid-WAIT:** `rst_i` is pulsed low. All outputs go to their reset values immediately. After release, a new Get from requester 3 completes normally.
